// File: rtl/mem_bus_arbiter.sv
// External memory bus arbiter/sequencer sharing one bus between the fetch and data ports.
// Define MEMARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module mem_bus_arbiter #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_gnt,
   output logic              fetch_done,
   output logic [DATA_W-1:0] fetch_data,
   input  logic              dmem_req,
   input  logic              dmem_we,
   input  logic [ADDR_W-1:0] dmem_addr,
   input  logic [DATA_W-1:0] dmem_wdata,
   output logic              dmem_gnt,
   output logic              dmem_done,
   output logic [DATA_W-1:0] dmem_rdata,
   output logic [ADDR_W-1:0] addr_bus,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic [DATA_W-1:0] data_in,
   output logic              ale,
   output logic              psen_n,
   output logic              rd_n,
   output logic              wr_n,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic       OWN_FETCH = 1'b0;
   localparam logic       OWN_DATA  = 1'b1;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t            state_r;
   state_t            state_next_s;
   logic              owner_r;
   logic              owner_next_s;
   logic              we_r;
   logic              we_next_s;
   logic [3:0]        cnt_r;
   logic [3:0]        cnt_next_s;
   logic              grant_s;
   logic              last_access_s;
   logic              tie_owner_s;

   logic              fetch_gnt_r;
   logic              fetch_done_r;
   logic [DATA_W-1:0] fetch_data_r;
   logic              dmem_gnt_r;
   logic              dmem_done_r;
   logic [DATA_W-1:0] dmem_rdata_r;
   logic [ADDR_W-1:0] addr_bus_r;
   logic [DATA_W-1:0] data_out_r;
   logic              data_oe_r;
   logic              ale_r;
   logic              psen_n_r;
   logic              rd_n_r;
   logic              wr_n_r;
   logic              busy_r;

`ifdef MEMARB_RR_EN
   logic              last_owner_r;

   assign tie_owner_s = ~last_owner_r;

   // Remember who was granted last so a tie goes to the other requester.
   always_ff @(posedge clk) begin
      if (reset) begin
         last_owner_r <= OWN_FETCH;
      end else if (grant_s) begin
         last_owner_r <= owner_next_s;
      end
   end
`else
   assign tie_owner_s = OWN_DATA;
`endif

   // FSM state, owner, direction and wait-counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
         owner_r <= OWN_FETCH;
         we_r    <= 1'b0;
         cnt_r   <= 4'd0;
      end else begin
         state_r <= state_next_s;
         owner_r <= owner_next_s;
         we_r    <= we_next_s;
         cnt_r   <= cnt_next_s;
      end
   end

   // Next-state, arbitration and wait-counter logic.
   always_comb begin
      state_next_s  = state_r;
      owner_next_s  = owner_r;
      we_next_s     = we_r;
      cnt_next_s    = cnt_r;
      grant_s       = 1'b0;
      last_access_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fetch_req || dmem_req) begin
               grant_s      = 1'b1;
               state_next_s = ST_ADDR;
               if (fetch_req && dmem_req) begin
                  owner_next_s = tie_owner_s;
               end else if (dmem_req) begin
                  owner_next_s = OWN_DATA;
               end else begin
                  owner_next_s = OWN_FETCH;
               end
               we_next_s = (owner_next_s == OWN_DATA) ? dmem_we : 1'b0;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            state_next_s = ST_ACCESS;
            cnt_next_s   = WAIT_LOAD;
         end
         ST_ACCESS: begin
            if (cnt_r == 4'd0) begin
               last_access_s = 1'b1;
               state_next_s  = ST_DONE;
            end else begin
               cnt_next_s = cnt_r - 4'd1;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Registered bus and handshake outputs, derived from the state being entered.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_gnt_r  <= 1'b0;
         fetch_done_r <= 1'b0;
         fetch_data_r <= '0;
         dmem_gnt_r   <= 1'b0;
         dmem_done_r  <= 1'b0;
         dmem_rdata_r <= '0;
         addr_bus_r   <= '0;
         data_out_r   <= '0;
         data_oe_r    <= 1'b0;
         ale_r        <= 1'b0;
         psen_n_r     <= 1'b1;
         rd_n_r       <= 1'b1;
         wr_n_r       <= 1'b1;
         busy_r       <= 1'b0;
      end else begin
         fetch_gnt_r  <= grant_s && (owner_next_s == OWN_FETCH);
         dmem_gnt_r   <= grant_s && (owner_next_s == OWN_DATA);
         ale_r        <= (state_next_s == ST_ADDR);
         psen_n_r     <= !((state_next_s == ST_ACCESS) && (owner_next_s == OWN_FETCH));
         rd_n_r       <= !((state_next_s == ST_ACCESS) && (owner_next_s == OWN_DATA) && !we_next_s);
         wr_n_r       <= !((state_next_s == ST_ACCESS) && (owner_next_s == OWN_DATA) && we_next_s);
         fetch_done_r <= (state_next_s == ST_DONE) && (owner_next_s == OWN_FETCH);
         dmem_done_r  <= (state_next_s == ST_DONE) && (owner_next_s == OWN_DATA);
         data_oe_r    <= (state_next_s != ST_IDLE) && (owner_next_s == OWN_DATA) && we_next_s;
         busy_r       <= (state_next_s != ST_IDLE);
         if (grant_s) begin
            addr_bus_r <= (owner_next_s == OWN_DATA) ? dmem_addr : fetch_addr;
         end
         if (grant_s && (owner_next_s == OWN_DATA) && dmem_we) begin
            data_out_r <= dmem_wdata;
         end
         // Read data is captured on the edge that leaves the final strobe cycle.
         if (last_access_s && (owner_r == OWN_FETCH)) begin
            fetch_data_r <= data_in;
         end
         if (last_access_s && (owner_r == OWN_DATA) && !we_r) begin
            dmem_rdata_r <= data_in;
         end
      end
   end

   assign fetch_gnt  = fetch_gnt_r;
   assign fetch_done = fetch_done_r;
   assign fetch_data = fetch_data_r;
   assign dmem_gnt   = dmem_gnt_r;
   assign dmem_done  = dmem_done_r;
   assign dmem_rdata = dmem_rdata_r;
   assign addr_bus   = addr_bus_r;
   assign data_out   = data_out_r;
   assign data_oe    = data_oe_r;
   assign ale        = ale_r;
   assign psen_n     = psen_n_r;
   assign rd_n       = rd_n_r;
   assign wr_n       = wr_n_r;
   assign busy       = busy_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized bench for mem_bus_arbiter: three instances (WAIT_CYCLES 2, 1, 15) checked
// every cycle against a transaction-position reference model.
module tb_mem_bus_arbiter;

   localparam int N = 3;
   localparam int WCS [N] = '{2, 1, 15};

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        fetch_req  [N];
   logic [15:0] fetch_addr [N];
   logic        fetch_gnt  [N];
   logic        fetch_done [N];
   logic [7:0]  fetch_data [N];
   logic        dmem_req   [N];
   logic        dmem_we    [N];
   logic [15:0] dmem_addr  [N];
   logic [7:0]  dmem_wdata [N];
   logic        dmem_gnt   [N];
   logic        dmem_done  [N];
   logic [7:0]  dmem_rdata [N];
   logic [15:0] addr_bus   [N];
   logic [7:0]  data_out   [N];
   logic        data_oe    [N];
   logic [7:0]  data_in    [N];
   logic        ale        [N];
   logic        psen_n     [N];
   logic        rd_n       [N];
   logic        wr_n       [N];
   logic        busy       [N];

   for (genvar g = 0; g < N; g++) begin : g_dut
      mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(WCS[g])) u_dut (
         .clk(clk), .reset(reset),
         .fetch_req(fetch_req[g]), .fetch_addr(fetch_addr[g]), .fetch_gnt(fetch_gnt[g]),
         .fetch_done(fetch_done[g]), .fetch_data(fetch_data[g]),
         .dmem_req(dmem_req[g]), .dmem_we(dmem_we[g]), .dmem_addr(dmem_addr[g]),
         .dmem_wdata(dmem_wdata[g]), .dmem_gnt(dmem_gnt[g]), .dmem_done(dmem_done[g]),
         .dmem_rdata(dmem_rdata[g]), .addr_bus(addr_bus[g]), .data_out(data_out[g]),
         .data_oe(data_oe[g]), .data_in(data_in[g]), .ale(ale[g]), .psen_n(psen_n[g]),
         .rd_n(rd_n[g]), .wr_n(wr_n[g]), .busy(busy[g])
      );
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model: m_pos = cycles since grant (-1 idle); grant cycle 0, strobe 1..W, done W+1.
   int          m_pos   [N];
   logic        m_owner [N];
   logic        m_we    [N];
   logic        m_last  [N];
   logic [15:0] m_addr  [N];
   logic [7:0]  m_wdata [N];
   logic [7:0]  m_fdata [N];
   logic [7:0]  m_rdata [N];
   int          run_len [N];
   int          gnt_cyc [N];

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   task automatic model_edge(input int g);
      int   w;
      logic own;
      w = WCS[g];
      if (reset) begin
         m_pos[g] = -1; m_last[g] = 1'b0; m_addr[g] = '0; m_wdata[g] = '0;
         m_fdata[g] = '0; m_rdata[g] = '0; m_owner[g] = 1'b0; m_we[g] = 1'b0;
      end else if (m_pos[g] < 0) begin
         if (fetch_req[g] || dmem_req[g]) begin
            if (fetch_req[g] && dmem_req[g]) begin
`ifdef MEMARB_RR_EN
               own = !m_last[g];
`else
               own = 1'b1;
`endif
            end else begin
               own = dmem_req[g];
            end
            m_owner[g] = own;
            m_last[g]  = own;
            m_we[g]    = own && dmem_we[g];
            m_addr[g]  = own ? dmem_addr[g] : fetch_addr[g];
            if (own && dmem_we[g]) m_wdata[g] = dmem_wdata[g];
            m_pos[g] = 0;
         end
      end else if (m_pos[g] == w + 1) begin
         m_pos[g] = -1;
      end else begin
         if (m_pos[g] == w) begin
            if (!m_owner[g]) m_fdata[g] = data_in[g];
            else if (!m_we[g]) m_rdata[g] = data_in[g];
         end
         m_pos[g]++;
      end
   endtask

   task automatic check_outputs(input int g, input logic was_reset);
      int         p, w;
      logic       own, we, strb;
      logic [9:0] exp_c, got_c;
      p = m_pos[g]; w = WCS[g]; own = m_owner[g]; we = m_we[g];
      strb = (p >= 1) && (p <= w);
      exp_c = {p == 0, (p == 0) && !own, (p == 0) && own,
               !(strb && !own), !(strb && own && !we), !(strb && own && we),
               (p == w + 1) && !own, (p == w + 1) && own, p >= 0, (p >= 0) && own && we};
      got_c = {ale[g], fetch_gnt[g], dmem_gnt[g], psen_n[g], rd_n[g], wr_n[g],
               fetch_done[g], dmem_done[g], busy[g], data_oe[g]};
      check_eq($sformatf("ctrl%0d", g), 32'(got_c), 32'(exp_c));
      check_eq($sformatf("addr_bus%0d", g), 32'(addr_bus[g]), 32'(m_addr[g]));
      check_eq($sformatf("data_out%0d", g), 32'(data_out[g]), 32'(m_wdata[g]));
      check_eq($sformatf("fetch_data%0d", g), 32'(fetch_data[g]), 32'(m_fdata[g]));
      check_eq($sformatf("dmem_rdata%0d", g), 32'(dmem_rdata[g]), 32'(m_rdata[g]));
      // Direct measurements of strobe width and grant-to-done distance.
      if (was_reset) begin
         run_len[g] = 0;
         gnt_cyc[g] = -1;
      end else begin
         if (!(psen_n[g] && rd_n[g] && wr_n[g])) begin
            run_len[g]++;
         end else if (run_len[g] > 0) begin
            check_eq($sformatf("strobe_width%0d", g), 32'(run_len[g]), 32'(w));
            run_len[g] = 0;
         end
         if (fetch_gnt[g] || dmem_gnt[g]) gnt_cyc[g] = cyc;
         if (fetch_done[g] || dmem_done[g])
            check_eq($sformatf("gnt_to_done%0d", g), 32'(cyc - gnt_cyc[g]), 32'(w + 1));
      end
   endtask

   task automatic step();
      logic r;
      @(posedge clk);
      r = reset;
      for (int g = 0; g < N; g++) model_edge(g);
      #1;
      cyc++;
      for (int g = 0; g < N; g++) check_outputs(g, r);
   endtask

   // mode 0: hold stimulus, drop req on done; 1: random traffic; 2: hold reqs, never drop
   task automatic run_cycles(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         step();
         reset = 1'b0;
         for (int g = 0; g < N; g++) begin
            if (mode != 2 && m_pos[g] == WCS[g] + 1) begin
               if (m_owner[g]) dmem_req[g] = 1'b0;
               else fetch_req[g] = 1'b0;
            end
            if (mode != 0) data_in[g] = 8'($urandom);
            if (mode == 1) begin
               if (!fetch_req[g] && $urandom_range(2) == 0) begin
                  fetch_req[g]  = 1'b1;
                  fetch_addr[g] = 16'($urandom);
               end
               if (!dmem_req[g] && $urandom_range(2) == 0) begin
                  dmem_req[g]   = 1'b1;
                  dmem_we[g]    = 1'($urandom);
                  dmem_addr[g]  = 16'($urandom);
                  dmem_wdata[g] = 8'($urandom);
               end
               if ($urandom_range(49) == 0) fetch_req[g] = 1'b0;
               if ($urandom_range(49) == 0) dmem_req[g] = 1'b0;
            end
         end
         if (mode == 1 && $urandom_range(199) == 0) reset = 1'b1;
      end
   endtask

   initial begin
      reset = 1'b1;
      for (int g = 0; g < N; g++) begin
         fetch_req[g] = 1'b0; fetch_addr[g] = '0; dmem_req[g] = 1'b0; dmem_we[g] = 1'b0;
         dmem_addr[g] = '0; dmem_wdata[g] = '0; data_in[g] = '0;
         m_pos[g] = -1; m_owner[g] = 1'b0; m_we[g] = 1'b0; m_last[g] = 1'b0;
         m_addr[g] = '0; m_wdata[g] = '0; m_fdata[g] = '0; m_rdata[g] = '0;
         run_len[g] = 0; gnt_cyc[g] = -1;
      end
      step(); step(); step();
      reset = 1'b0;
      step();

      // Single fetch of A845 returning 74.
      for (int g = 0; g < N; g++) begin
         fetch_req[g] = 1'b1; fetch_addr[g] = 16'hA845; data_in[g] = 8'h74;
      end
      run_cycles(22, 0);
      check_eq("fetch_byte", 32'(fetch_data[0]), 32'h74);

      // Data write of 5A to 0030.
      for (int g = 0; g < N; g++) begin
         dmem_req[g] = 1'b1; dmem_we[g] = 1'b1; dmem_addr[g] = 16'h0030; dmem_wdata[g] = 8'h5A;
      end
      run_cycles(22, 0);
      check_eq("write_byte", 32'(data_out[0]), 32'h5A);

      // Both requesters held continuously.
      for (int g = 0; g < N; g++) begin
         fetch_req[g] = 1'b1; fetch_addr[g] = 16'h1234;
         dmem_req[g] = 1'b1; dmem_we[g] = 1'b0; dmem_addr[g] = 16'h4321;
      end
      run_cycles(60, 2);
      for (int g = 0; g < N; g++) begin
         fetch_req[g] = 1'b0; dmem_req[g] = 1'b0;
      end
      run_cycles(20, 0);

      // Reset during ACCESS, then a fresh fetch completes.
      for (int g = 0; g < N; g++) begin
         fetch_req[g] = 1'b1; fetch_addr[g] = 16'h0F0F; data_in[g] = 8'hC3;
      end
      step(); step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_cycles(22, 0);

      // Requester drops its req right after the grant.
      for (int g = 0; g < N; g++) begin
         dmem_req[g] = 1'b1; dmem_we[g] = 1'b0; dmem_addr[g] = 16'hBEEF; data_in[g] = 8'h96;
      end
      step();
      for (int g = 0; g < N; g++) dmem_req[g] = 1'b0;
      run_cycles(22, 0);
      check_eq("read_byte", 32'(dmem_rdata[0]), 32'h96);

      run_cycles(3000, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
